// File: rtl/grid_pkg.sv
// Shared definitions for the grid logic family: combine modes and the ring
// neighbour-combine helper used by the pipeline stages.
package grid_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_PASS = 2'd3
  } op_e;

  localparam int RING_MAX_W = 64;

  // Bit i of the result is d[i] OP d[(i+1) mod w]; bits at and above w are zero.
  // The neighbour vector is a rotate-right by one built from shifts and a mask,
  // so w=1 naturally pairs each bit with itself.
  function automatic logic [RING_MAX_W-1:0] ring_combine(
    input logic [RING_MAX_W-1:0] d,
    input int unsigned           w,
    input op_e                   op
  );
    logic [RING_MAX_W-1:0] mask;
    logic [RING_MAX_W-1:0] dm;
    logic [RING_MAX_W-1:0] rot;
    logic [RING_MAX_W-1:0] res;
    mask = ~({RING_MAX_W{1'b1}} << w);
    dm   = d & mask;
    rot  = ((dm >> 1) | (dm << (w - 1))) & mask;
    case (op)
      OP_AND:  res = dm & rot;
      OP_OR:   res = dm | rot;
      OP_XOR:  res = dm ^ rot;
      default: res = dm;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ring_op_stage.sv
// One pipeline register (valid/data/op) with its combine logic on the input side
// and its link in the combinational ready chain.
module ring_op_stage
  import grid_pkg::*;
#(
  parameter int W      = 3,
  parameter bit BYPASS = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         v_i,
  input  logic [W-1:0] d_i,
  input  op_e          op_i,
  input  logic         rdy_i,
  output logic         rdy_o,
  output logic         v_o,
  output logic [W-1:0] d_o,
  output op_e          op_o
);

  logic         v_q;
  logic [W-1:0] d_q;
  op_e          op_q;
  logic [W-1:0] d_d;

  generate
    if (BYPASS) begin : g_bypass
      assign d_d = d_i;
    end else begin : g_comb
      assign d_d = W'(ring_combine(RING_MAX_W'(d_i), W, op_i));
    end
  endgenerate

  // An empty stage can always take a beat, so bubbles collapse toward the output.
  assign rdy_o = !v_q || rdy_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q  <= 1'b0;
      d_q  <= '0;
      op_q <= OP_AND;
    end else if (rdy_o) begin
      v_q <= v_i;
      if (v_i) begin
        d_q  <= d_d;
        op_q <= op_i;
      end
    end
  end

  assign v_o  = v_q;
  assign d_o  = d_q;
  assign op_o = op_q;

endmodule

// File: rtl/ring_op_pipe.sv
// Ready/valid neighbour-combine pipeline: DEPTH stages, stage 0 captures the beat
// as-is, later stages apply the ring combine selected by the beat's op.
module ring_op_pipe
  import grid_pkg::*;
#(
  parameter int W     = 3,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [1:0]       out_op,
  output logic             busy,
  output logic [CNT_W-1:0] beat_cnt
);

  logic [DEPTH:0]            rdy;
  logic [DEPTH-1:0]          v;
  logic [DEPTH-1:0][W-1:0]   d;
  op_e                       op [DEPTH];
  logic [CNT_W-1:0]          beat_cnt_q;
  logic [CNT_W-1:0]          beat_cnt_d;

  assign rdy[DEPTH] = out_ready;
  assign in_ready   = rdy[0];

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stg
      if (k == 0) begin : g_head
        ring_op_stage #(.W(W), .BYPASS(1'b1)) u_stg (
          .clk   (clk),
          .rst   (rst),
          .v_i   (in_valid),
          .d_i   (in_data),
          .op_i  (op_e'(in_op)),
          .rdy_i (rdy[k+1]),
          .rdy_o (rdy[k]),
          .v_o   (v[k]),
          .d_o   (d[k]),
          .op_o  (op[k])
        );
      end else begin : g_body
        ring_op_stage #(.W(W), .BYPASS(1'b0)) u_stg (
          .clk   (clk),
          .rst   (rst),
          .v_i   (v[k-1]),
          .d_i   (d[k-1]),
          .op_i  (op[k-1]),
          .rdy_i (rdy[k+1]),
          .rdy_o (rdy[k]),
          .v_o   (v[k]),
          .d_o   (d[k]),
          .op_o  (op[k])
        );
      end
    end
  endgenerate

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign out_op    = op[DEPTH-1];
  assign busy      = |v;

  // Delivered-beat counter sticks at all-ones instead of wrapping.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (out_valid && out_ready && (beat_cnt_q != {CNT_W{1'b1}}))
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) beat_cnt_q <= '0;
    else     beat_cnt_q <= beat_cnt_d;
  end

  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_ring_op_pipe.sv
// Directed bench for ring_op_pipe: main W=3/DEPTH=3 instance plus small
// instances for counter saturation, W=1 and DEPTH=1.
module tb_ring_op_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  in_data, out_data;
  logic [1:0]  in_op, out_op;
  logic [15:0] beat_cnt;

  logic        s_in_ready, s_out_valid, s_busy;
  logic [2:0]  s_out_data;
  logic [1:0]  s_out_op, s_beat_cnt;

  logic        w1_in_valid, w1_in_ready, w1_out_valid, w1_out_ready, w1_busy;
  logic [0:0]  w1_in_data, w1_out_data;
  logic [1:0]  w1_in_op, w1_out_op;
  logic [7:0]  w1_beat_cnt;

  logic        d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_busy;
  logic [2:0]  d1_in_data, d1_out_data;
  logic [1:0]  d1_in_op, d1_out_op;
  logic [7:0]  d1_beat_cnt;

  ring_op_pipe #(.W(3), .DEPTH(3), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_op(out_op), .busy(busy), .beat_cnt(beat_cnt));

  ring_op_pipe #(.W(3), .DEPTH(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_op(in_op), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_op(s_out_op), .busy(s_busy), .beat_cnt(s_beat_cnt));

  ring_op_pipe #(.W(1), .DEPTH(3), .CNT_W(8)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
    .in_data(w1_in_data), .in_op(w1_in_op), .out_valid(w1_out_valid),
    .out_ready(w1_out_ready), .out_data(w1_out_data), .out_op(w1_out_op),
    .busy(w1_busy), .beat_cnt(w1_beat_cnt));

  ring_op_pipe #(.W(3), .DEPTH(1), .CNT_W(8)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .in_data(d1_in_data), .in_op(d1_in_op), .out_valid(d1_out_valid),
    .out_ready(d1_out_ready), .out_data(d1_out_data), .out_op(d1_out_op),
    .busy(d1_busy), .beat_cnt(d1_beat_cnt));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single beat into an empty pipe with out_ready high; checks latency and result.
  task automatic one_beat(input string tag, input logic [2:0] din, input logic [1:0] op,
                          input logic [31:0] exp);
    int lat;
    in_valid = 1'b1; in_data = din; in_op = op; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick;
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_data"}, 32'(out_data), exp);
    chk({tag, "_op"}, 32'(out_op), 32'(op));
    tick;
  endtask

  // Drains the pipe with out_ready high, checking delivered beats in order.
  task automatic drain(input string tag, input int n, input logic [31:0] e [4]);
    int dn;
    dn = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) in_valid = 1'b0;
      #1;
      if (out_valid) begin
        if (dn < n) chk(tag, 32'(out_data), e[dn]);
        dn++;
      end
      tick;
    end
    chk({tag, "_n"}, dn, n);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  bd [4];
    logic [31:0] bexp [4];
    int          got, first, acc;
    logic [2:0]  nxt;

    in_valid = 0; in_data = '0; in_op = '0; out_ready = 0;
    w1_in_valid = 0; w1_in_data = '0; w1_in_op = '0; w1_out_ready = 0;
    d1_in_valid = 0; d1_in_data = '0; d1_in_op = '0; d1_out_ready = 0;

    #1;
    chk("rst_state", 32'({out_valid, busy, out_data, out_op}), 0);
    chk("rst_cnt", 32'(beat_cnt), 0);
    chk("rst_aux", 32'({s_in_ready, s_out_valid, s_out_data, s_out_op, s_busy,
                        w1_in_ready, w1_out_valid, w1_out_data, w1_out_op, w1_busy,
                        d1_in_ready, d1_out_valid, d1_out_data, d1_out_op, d1_busy}),
        32'({8'h80, 6'b10_0000, 8'h80}));
    chk("rst_aux_cnt", 32'({s_beat_cnt, w1_beat_cnt, d1_beat_cnt}), 0);
    tick;
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 32'(in_ready), 1);

    one_beat("and111", 3'b111, 2'd0, 'b111);
    chk("cnt_1", 32'(beat_cnt), 1);
    chk("sat_1", 32'(s_beat_cnt), 1);

    // Four modes back-to-back.
    bd   = '{3'b011, 3'b001, 3'b001, 3'b101};
    bexp = '{32'b000, 32'b111, 32'b011, 32'b101};
    got = 0; first = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) begin
        in_valid = 1'b1; in_data = bd[c]; in_op = 2'(c);
      end else begin
        in_valid = 1'b0;
      end
      tick;
      if (out_valid) begin
        if (got == 0) first = c;
        if (got < 4) begin
          chk("b2b_data", 32'(out_data), bexp[got]);
          chk("b2b_op", 32'(out_op), got);
          if (got > 0) chk("b2b_cyc", c, first + got);
        end
        got++;
      end
    end
    chk("b2b_n", got, 4);
    chk("cnt_5", 32'(beat_cnt), 5);
    chk("sat_5", 32'(s_beat_cnt), 3);

    // Backpressure: three accepts fill the pipe, then in_ready drops.
    out_ready = 1'b0; in_op = 2'd3; acc = 0; nxt = 3'd1;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_data = nxt;
      #1;
      chk("bp_rdy", 32'(in_ready), (c < 3) ? 1 : 0);
      if (in_ready) acc++;
      tick;
      if (c < 3) nxt = nxt + 3'd1;
    end
    chk("bp_acc", acc, 3);
    chk("bp_out", 32'({out_valid, busy, out_data}), 'b11_001);
    tick; tick;
    chk("bp_hold", 32'({out_valid, out_data}), 'b1_001);
    in_valid = 1'b1; in_data = 3'd4; out_ready = 1'b1;
    #1;
    chk("bp_rdy_rise", 32'(in_ready), 1);
    drain("bp_drain", 4, '{32'd1, 32'd2, 32'd3, 32'd4});
    chk("cnt_9", 32'(beat_cnt), 9);
    chk("sat_9", 32'(s_beat_cnt), 3);

    // Bubble collapse: A reaches the output, B enters behind it while stalled.
    in_valid = 1'b1; in_data = 3'b110; in_op = 2'd3; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    tick; tick;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 3'b011;
    #1;
    chk("bub_rdy_b", 32'(in_ready), 1);
    tick;
    in_valid = 1'b0;
    #1;
    chk("bub_two", 32'({out_valid, busy, in_ready}), 'b111);
    tick;
    chk("bub_hold", 32'({in_ready, out_data}), 'b1_110);
    in_valid = 1'b1; in_data = 3'b100;
    tick;
    in_valid = 1'b0;
    #1;
    chk("bub_full", 32'(in_ready), 0);
    drain("bub_drain", 3, '{32'b110, 32'b011, 32'b100, 32'd0});
    chk("cnt_12", 32'(beat_cnt), 12);

    // Reset with three beats in flight.
    out_ready = 1'b0; in_op = 2'd0; in_data = 3'b111; in_valid = 1'b1;
    tick; tick; tick;
    in_valid = 1'b0;
    #1;
    chk("mid_full", 32'({out_valid, busy, in_ready}), 'b110);
    rst = 1'b1;
    #1;
    chk("mid_rst", 32'({out_valid, busy}), 0);
    chk("mid_rst_cnt", 32'(beat_cnt), 0);
    chk("mid_rst_sat", 32'(s_beat_cnt), 0);
    tick;
    rst = 1'b0;
    one_beat("post_rst", 3'b001, 2'd2, 'b011);
    chk("post_rst_cnt", 32'(beat_cnt), 1);

    // W=1 XOR clears the bit; DEPTH=1 passes the beat through after one edge.
    w1_in_valid = 1'b1; w1_in_data = 1'b1; w1_in_op = 2'd2; w1_out_ready = 1'b1;
    d1_in_valid = 1'b1; d1_in_data = 3'b001; d1_in_op = 2'd2; d1_out_ready = 1'b1;
    tick;
    w1_in_valid = 1'b0; d1_in_valid = 1'b0;
    chk("d1_out", 32'({d1_out_valid, d1_out_data, d1_out_op}), 'b1_001_10);
    tick;
    chk("d1_cnt", 32'(d1_beat_cnt), 1);
    tick;
    chk("w1_out", 32'({w1_out_valid, w1_out_data, w1_out_op}), 'b1_0_10);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
